cas_sort_ctrl: RTL and testbench

Sequencing controller that sorts a frame of N stochastic-number-generator-width words in ascending order. It time-shares a single `cas` compare-and-swap instance across all pairs using an odd-even transposition schedule. It sits between an upstream word source and a downstream consumer, with ready/valid handshakes on both sides. It owns the N-entry register file and all sort sequencing.

---
 rtl/cas_sort_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cas_sort_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_sort_ctrl.sv
// cas / cas_sort_ctrl
//
// cas: combinational compare-and-swap. lt_out gets the smaller operand and
// gt_out the larger. Equal operands pass straight through (lt_out = a,
// gt_out = b), so equal keys keep their order.
//   a, b           : unsigned operands
//   lt_out, gt_out : ordered results
//
// cas_sort_ctrl: collects a frame of N words, sorts them in ascending order
// with an odd-even transposition schedule on a single shared cas, then
// streams them out lowest first. Frames do not overlap.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data is the word
//   out_valid/out_ready  : downstream handshake, out_data is the sorted word
//   busy                 : high during every compare cycle

module cas #(
    parameter int SNG_WIDTH = 4
) (
    input  logic [SNG_WIDTH-1:0] a,
    input  logic [SNG_WIDTH-1:0] b,
    output logic [SNG_WIDTH-1:0] lt_out,
    output logic [SNG_WIDTH-1:0] gt_out
);
    logic [SNG_WIDTH:0] diff;
    logic               swap;

    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        // No borrow and a non-zero difference means a > b strictly.
        swap = ~diff[SNG_WIDTH] && (diff[SNG_WIDTH-1:0] != '0);
        if (swap) begin
            lt_out = b;
            gt_out = a;
        end else begin
            lt_out = a;
            gt_out = b;
        end
    end
endmodule

// state | meaning
// LOAD  | accepting words into mem[wr_idx]
// SORT  | one compare-and-swap per cycle, phase/pair walk the schedule
// DRAIN | presenting mem[rd_idx] downstream
module cas_sort_ctrl #(
    parameter int SNG_WIDTH = 4,
    parameter int N         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SNG_WIDTH-1:0] out_data,
    output logic                 busy
);
    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] EVEN_LAST = IW'(N / 2 - 1);
    localparam logic [IW-1:0] ODD_LAST  = IW'(N / 2 - 2);
    // With N = 2 the odd phase has no pairs, so the sort ends after phase 0.
    localparam logic [PW-1:0] LAST_PHASE = PW'((N == 2) ? 0 : N - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SNG_WIDTH-1:0] mem [N];
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic [IW-1:0]        pair;
    logic [PW-1:0]        phase;

    logic [IW-1:0]        idx_a;
    logic [IW-1:0]        idx_b;
    logic [SNG_WIDTH-1:0] cas_lt;
    logic [SNG_WIDTH-1:0] cas_gt;
    logic                 last_pair;
    logic                 sort_done;
    logic                 load_fire;
    logic                 drain_fire;

    // Odd phases start one word higher: i = 2*pair + phase[0].
    assign idx_a = IW'({pair, 1'b0}) + IW'(phase[0]);
    assign idx_b = idx_a + IW'(1);

    assign last_pair = phase[0] ? (pair == ODD_LAST) : (pair == EVEN_LAST);
    assign sort_done = last_pair && (phase == LAST_PHASE);

    assign load_fire  = in_valid && in_ready;
    assign drain_fire = out_valid && out_ready;

    assign out_data = mem[rd_idx];

    cas #(
        .SNG_WIDTH(SNG_WIDTH)
    ) u_cas (
        .a     (mem[idx_a]),
        .b     (mem[idx_b]),
        .lt_out(cas_lt),
        .gt_out(cas_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wr_idx == LAST_IDX)) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && (rd_idx == LAST_IDX)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            pair   <= '0;
            phase  <= '0;
            for (int k = 0; k < N; k++) begin
                mem[k] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        mem[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            pair   <= '0;
                            phase  <= '0;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT: begin
                    mem[idx_a] <= cas_lt;
                    mem[idx_b] <= cas_gt;
                    if (last_pair) begin
                        pair  <= '0;
                        phase <= phase + PW'(1);
                        if (sort_done) begin
                            rd_idx <= '0;
                        end
                    end else begin
                        pair <= pair + IW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_fire) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cas_sort_ctrl.sv
// Bench for cas_sort_ctrl (SNG_WIDTH=4, N=8). A frame-level reference model
// (queue of received words, sorted copy, fixed sort duration) predicts the
// handshake outputs and the drained word every cycle; directed frames pin
// the model with literal expected sequences.
module tb_cas_sort_ctrl;
    localparam int W = 4;
    localparam int N = 8;
    localparam int SORT_CYCLES = (N / 2) * (N / 2) + (N / 2) * (N / 2 - 1);

    localparam int M_LOAD  = 0;
    localparam int M_SORT  = 1;
    localparam int M_DRAIN = 2;

    typedef logic [W-1:0] frame_t [N];
    typedef logic [W-1:0] word_q_t [$];

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    cas_sort_ctrl #(
        .SNG_WIDTH(W),
        .N        (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, advanced on every rising edge from the driven inputs.
    bit      model_ok = 1'b0;
    int      m_mode   = M_LOAD;
    int      m_left   = 0;
    word_q_t m_frame;
    word_q_t m_out;

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            m_mode   = M_LOAD;
            m_frame.delete();
            m_out.delete();
        end else if (model_ok) begin
            case (m_mode)
                M_LOAD: if (in_valid) begin
                    m_frame.push_back(in_data);
                    if (m_frame.size() == N) begin
                        m_out = m_frame;
                        m_out.sort();
                        m_frame.delete();
                        m_left = SORT_CYCLES;
                        m_mode = M_SORT;
                    end
                end
                M_SORT: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_DRAIN;
                end
                M_DRAIN: if (out_ready) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0) m_mode = M_LOAD;
                end
                default: m_mode = M_LOAD;
            endcase
        end
    end

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // One cycle: compare at the falling edge, then return 1 time unit later
    // so the caller can drive the next inputs.
    task automatic tick();
        @(negedge clk);
        if (model_ok) begin
            chk("in_ready", int'(in_ready), int'(m_mode == M_LOAD));
            chk("busy", int'(busy), int'(m_mode == M_SORT));
            chk("out_valid", int'(out_valid), int'(m_mode == M_DRAIN));
            if (m_mode == M_DRAIN && m_out.size() > 0)
                chk("out_data", int'(out_data), int'(m_out[0]));
        end
        #1;
    endtask

    // mode 0: in_valid held high, 1: toggling 1,0,1,0, 2: random
    task automatic send_frame(input frame_t f, input int mode);
        int k = 0;
        int cyc = 0;
        while (k < N && cyc < 400) begin
            tick();
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(3) != 0);
            endcase
            in_data = f[k];
            if (in_valid && in_ready) k++;
            cyc++;
        end
        chk("send_count", k, N);
    endtask

    // Collects N drained words. stall_at >= 0 holds out_ready low for 3
    // cycles once that many words have been taken.
    task automatic recv_frame(input int stall_at, input bit rnd,
                              output word_q_t got, output int bc);
        int cyc = 0;
        int stall = 0;
        logic [W-1:0] held = '0;
        got.delete();
        bc = 0;
        while (got.size() < N && cyc < 800) begin
            tick();
            in_valid = 1'b0;
            if (busy) bc++;
            if (out_valid && got.size() == stall_at && stall < 3) begin
                if (stall == 0) held = out_data;
                else chk("stall_hold", int'(out_data), int'(held));
                out_ready = 1'b0;
                stall++;
            end else if (rnd) begin
                out_ready = ($urandom_range(3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            cyc++;
        end
        chk("recv_count", got.size(), N);
    endtask

    task automatic check_frame(string name, word_q_t got, frame_t exp);
        for (int i = 0; i < N; i++) begin
            if (i < got.size()) chk(name, int'(got[i]), int'(exp[i]));
            else chk(name, -1, int'(exp[i]));
        end
    endtask

    initial begin
        frame_t  f;
        frame_t  e;
        word_q_t got;
        int      bc;
        int      cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);

        // Reverse order
        f = '{15, 13, 11, 9, 7, 5, 3, 1};
        e = '{1, 3, 5, 7, 9, 11, 13, 15};
        send_frame(f, 0);
        recv_frame(-1, 1'b0, got, bc);
        chk("rev_busy_cycles", bc, 28);
        check_frame("rev_out", got, e);

        // Already sorted
        f = '{0, 1, 2, 3, 4, 5, 6, 7};
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_frame(f, 0);
        recv_frame(-1, 1'b0, got, bc);
        chk("sorted_busy_cycles", bc, 28);
        check_frame("sorted_out", got, e);

        // Duplicates and extremes
        f = '{3, 3, 15, 0, 1, 15, 0, 1};
        e = '{0, 0, 1, 1, 3, 3, 15, 15};
        send_frame(f, 0);
        recv_frame(-1, 1'b0, got, bc);
        check_frame("dup_out", got, e);

        // in_valid gaps and an output stall at index 4
        f = '{9, 2, 14, 7, 0, 11, 5, 3};
        e = '{0, 2, 3, 5, 7, 9, 11, 14};
        send_frame(f, 1);
        recv_frame(4, 1'b0, got, bc);
        check_frame("stall_out", got, e);

        // Reset in the middle of SORT
        f = '{4, 8, 1, 12, 6, 2, 10, 0};
        send_frame(f, 0);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 10; c++) begin
            tick();
            in_valid = 1'b0;
            if (busy) cnt++;
        end
        chk("sort_reached", cnt, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        for (int c = 0; c < 4; c++) tick();
        f = '{7, 6, 5, 4, 3, 2, 1, 0};
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_frame(f, 0);
        recv_frame(-1, 1'b0, got, bc);
        check_frame("post_rst_out", got, e);

        // Randomized frames, back to back, with random handshakes
        for (int fr = 0; fr < 8; fr++) begin
            for (int i = 0; i < N; i++) f[i] = W'($urandom_range(15));
            send_frame(f, (fr < 2) ? 0 : 2);
            recv_frame(-1, fr >= 2, got, bc);
        end
        for (int c = 0; c < 3; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
